// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared op codes, FSM state type and flag bit positions for
//                the ALU arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Single-cycle combinational ALU (AND/OR/ADD/SUB) with NZCV.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    import alu_arb_pkg::*;

    logic [WIDTH:0] w_sum;
    logic           w_carry;
    logic           w_ovf;

    always_comb begin
        w_sum   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        result  = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                w_sum   = {1'b0, a} + {1'b0, b};
                result  = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                // Carry is the inverted borrow: set when a >= b (unsigned).
                w_sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                result  = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = w_carry;
        flags[FLAG_V] = w_ovf;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker: first request at or after
//                the pointer, wrapping modulo NREQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        grant   = '0;
        gidx    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(ptr) + i) % NREQ;
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                gidx         = w_idx[IDW-1:0];
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one ALU between NREQ requesters with
//                a registered, id-tagged response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [WIDTH-1:0]     resp_result,
    output logic [3:0]           resp_flags,
    output logic                 busy
);
    import alu_arb_pkg::*;

    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    arb_state_t       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_result;
    logic [3:0]       w_alu_flags;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .gidx  (w_gidx)
    );

    // The ALU only ever sees captured operands, so requesters may change
    // their buses freely once accepted.
    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    assign req_ready = (r_state == IDLE && !reset) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[w_gidx*WIDTH +: WIDTH];
                        r_b     <= req_b[w_gidx*WIDTH +: WIDTH];
                        r_op    <= req_op[w_gidx*3 +: 3];
                        resp_id <= w_gidx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result <= w_alu_result;
                    resp_flags  <= w_alu_flags;
                    resp_valid  <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_ptr      <= (resp_id == c_last_id) ? '0 : resp_id + 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter against a transaction
//                level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_result;
    logic [3:0]            resp_flags;
    logic                  busy;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: one outstanding transaction plus the rr pointer.
    int          m_ptr       = 0;
    int          m_accept    = 0;
    int          m_next_free = 0;
    bit          m_inflight  = 1'b0;
    int          m_id        = 0;
    logic [31:0] m_res       = '0;
    logic [3:0]  m_flg       = '0;
    int          acc_cyc[$];
    int          acc_id[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint          sa, sb, s;
        longint unsigned ua;
        logic [31:0]     r;
        logic            c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                ua = longint'({32'b0, a}) + longint'({32'b0, b});
                r  = ua[31:0];
                c  = (ua >= 64'h1_0000_0000);
                s  = sa + sb;
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_op[r*3 +: 3]  = op;
    endtask

    // Called right after a falling edge once inputs are set; checks this
    // cycle's outputs, advances the model across the next rising edge.
    task automatic step();
        int              g;
        bit              idle, rv;
        logic [NREQ-1:0] exp_ready;
        #1;
        idle      = !m_inflight && (cyc >= m_next_free);
        g         = idle ? exp_grant(req_valid, m_ptr) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, !idle);
        rv = m_inflight && (cyc >= m_accept + 2);
        check("resp_valid", resp_valid, rv);
        if (rv) begin
            check("resp_id", resp_id, m_id);
            check("resp_result", resp_result, m_res);
            check("resp_flags", resp_flags, m_flg);
        end
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && req_valid[i]) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(i);
            end
        if (rv && resp_ready) begin
            m_inflight  = 1'b0;
            m_ptr       = (m_id + 1) % NREQ;
            m_next_free = cyc + 1;
        end
        if (g >= 0) begin
            m_inflight = 1'b1;
            m_accept   = cyc;
            m_id       = g;
            {m_flg, m_res} = ref_alu(req_a[g*32 +: 32], req_b[g*32 +: 32], req_op[g*3 +: 3]);
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = '1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_result", resp_result, 0);
        check("rst_flags", resp_flags, 0);
        check("rst_id", resp_id, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        cyc       = 0;

        // Single ADD: accepted at t, response at t+2.
        resp_ready = 1'b1;
        drive(0, 32'h5, 32'h3, 3'b010);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        step();
        check("add_valid", resp_valid, 1);
        check("add_result", resp_result, 32'h8);
        check("add_flags", resp_flags, 4'b0000);
        check("add_id", resp_id, 0);
        step();
        step();

        // Carry and zero.
        drive(0, 32'hFFFF_FFFF, 32'h1, 3'b010);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        step();
        check("carry_result", resp_result, 32'h0);
        check("carry_flags", resp_flags, 4'b0110);
        step();
        step();

        // Signed overflow.
        drive(0, 32'h7FFF_FFFF, 32'h1, 3'b010);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        step();
        check("ovf_result", resp_result, 32'h8000_0000);
        check("ovf_flags", resp_flags, 4'b1001);
        step();
        step();

        // Round robin with both requesters continuously valid.
        drive(0, 32'h9, 32'h4, 3'b110);
        drive(1, 32'hF0, 32'h0F, 3'b001);
        acc_cyc.delete();
        acc_id.delete();
        req_valid = 2'b11;
        repeat (12) step();
        req_valid = '0;
        repeat (3) step();
        check("rr_count", acc_id.size(), 4);
        for (int k = 1; k < acc_id.size(); k++) begin
            check("rr_alternate", acc_id[k], (acc_id[0] + k) % 2);
            check("rr_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
        end

        // Backpressure: response held while consumer stalls.
        resp_ready = 1'b0;
        drive(0, 32'h1234_5678, 32'h0F0F_0F0F, 3'b000);
        req_valid = 2'b01;
        step();
        req_valid = 2'b11;
        repeat (6) step();
        check("bp_busy", busy, 1);
        check("bp_result", resp_result, 32'h0204_0608);
        resp_ready = 1'b1;
        repeat (2) step();
        req_valid = '0;
        repeat (4) step();

        // Reset during EXEC discards the in-flight op.
        drive(0, 32'h5, 32'h3, 3'b010);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        repeat (3) step();
        drive(1, 32'hAA, 32'h55, 3'b001);
        req_valid = 2'b11;
        step();
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", resp_result, 0);
        check("mid_rst_id", resp_id, 0);
        @(negedge clk);
        cyc++;
        reset       = 1'b0;
        m_inflight  = 1'b0;
        m_ptr       = 0;
        m_next_free = 0;
        repeat (3) step();
        acc_id.delete();
        acc_cyc.delete();
        req_valid = 2'b11;
        step();
        req_valid = '0;
        check("post_rst_grant", (acc_id.size() == 1) ? acc_id[0] : -1, 0);
        repeat (3) step();

        // Randomized traffic.
        repeat (400) begin
            req_valid  = NREQ'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NREQ; r++)
                drive(r, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
            step();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
